// File: rtl/raster_src_if.sv
// raster_src_if: frame-memory read bus plus video output bus of raster_src
// master drives rd_en/rd_addr/o_hav/o_vav/data_out and samples rd_data; slave is the memory/display side
interface raster_src_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_PARA  = 18
) ();
  logic                  rd_en;
  logic [ADDR_PARA-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  o_hav;
  logic                  o_vav;
  logic [DATA_WIDTH-1:0] data_out;
  modport master (output rd_en, rd_addr, o_hav, o_vav, data_out, input rd_data);
  modport slave (input rd_en, rd_addr, o_hav, o_vav, data_out, output rd_data);
endinterface

// File: rtl/raster_src.sv
// raster_src: raster scan source reading a frame memory line by line with H/V blanking
// ports: clk, rstb (async active-high), start/cont frame control, busy/done/frame_cnt status,
// bus = memory read strobe/address/data and video hav/vav/data outputs
module raster_src #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_PARA       = 18,
  parameter int WIDTH_IMG_PARA  = 512,
  parameter int HEIGHT_IMG_PARA = 512,
  parameter int H_BLANK_PARA    = 16,
  parameter int V_BLANK_PARA    = 544
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  input  logic       cont,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt,
  raster_src_if.master bus
);
  localparam int M1   = WIDTH_IMG_PARA > V_BLANK_PARA ? WIDTH_IMG_PARA : V_BLANK_PARA;
  localparam int MAXC = M1 > H_BLANK_PARA ? M1 : H_BLANK_PARA;
  localparam int CW   = $clog2(MAXC);
  localparam int LW   = HEIGHT_IMG_PARA > 1 ? $clog2(HEIGHT_IMG_PARA) : 1;
  typedef enum logic [1:0] {IDLE, HBLK, ACT, VBLK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, lim;
  logic [LW-1:0] line;
  logic last, last_line, vav, vav_d1, en_d1;
  always_comb begin
    lim = state == ACT ? CW'(WIDTH_IMG_PARA - 1) : state == VBLK ? CW'(V_BLANK_PARA - 1) : CW'(H_BLANK_PARA - 1);
    last = cnt == lim;
    last_line = line == LW'(HEIGHT_IMG_PARA - 1);
    vav = state == HBLK || state == ACT;
    busy = state != IDLE;
    done = state == VBLK && last;
    state_n = state == IDLE ? (start ? HBLK : IDLE) :
              !last         ? state :
              state == HBLK ? ACT :
              state == ACT  ? (last_line ? VBLK : HBLK) :
              (cont ? HBLK : IDLE);
  end
  // rd_en is registered from next state so it is high exactly while state==ACT;
  // the address wraps to 0 on the last pixel so nothing past the frame is ever presented
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state        <= IDLE;
      cnt          <= '0;
      line         <= '0;
      frame_cnt    <= '0;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      en_d1        <= 1'b0;
      vav_d1       <= 1'b0;
      bus.o_hav    <= 1'b0;
      bus.o_vav    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      state        <= state_n;
      cnt          <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      line         <= state == IDLE ? '0 : (state == ACT && last) ? (last_line ? '0 : line + 1'b1) : line;
      frame_cnt    <= frame_cnt + 8'(done);
      bus.rd_en    <= state_n == ACT;
      bus.rd_addr  <= (state == IDLE || done || (state == ACT && last && last_line)) ? '0 :
                      state == ACT ? bus.rd_addr + 1'b1 : bus.rd_addr;
      en_d1        <= bus.rd_en;
      vav_d1       <= vav;
      bus.o_hav    <= en_d1;
      bus.o_vav    <= vav_d1;
      bus.data_out <= en_d1 ? bus.rd_data : '0;
    end
  end
endmodule

// File: tb/tb_raster_src.sv
// tb_raster_src: directed table-driven bench for raster_src (4x3 image, H blank 2, V blank 20, mem[a]=a+10)
module tb_raster_src;
  logic clk, rstb, start, cont;
  logic busy, done;
  logic [7:0] frame_cnt;
  int n_vec = 0;
  int n_err = 0;
  raster_src_if #(.DATA_WIDTH(8), .ADDR_PARA(18)) bus ();
  raster_src #(
    .DATA_WIDTH(8), .ADDR_PARA(18), .WIDTH_IMG_PARA(4), .HEIGHT_IMG_PARA(3),
    .H_BLANK_PARA(2), .V_BLANK_PARA(20)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .cont(cont),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) bus.rd_data <= 8'(bus.rd_addr + 18'd10);
  typedef struct {
    int   cyc;
    logic st;
    logic en;
    int   addr;
    logic hav;
    logic vav;
    int   dat;
    logic bsy;
    logic dn;
    int   fc;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int c, logic s, logic e, int a, logic h, logic v, int d, logic b, logic dn, int f);
    vec_t r;
    r.cyc = c; r.st = s; r.en = e; r.addr = a; r.hav = h; r.vav = v;
    r.dat = d; r.bsy = b; r.dn = dn; r.fc = f;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [28:0] snap();
    return {bus.rd_en, bus.rd_addr[7:0], bus.o_hav, bus.o_vav, bus.data_out, busy, done, frame_cnt};
  endfunction
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc;
    rstb = 1'b1; start = 1'b0; cont = 1'b0;
    #3;
    chk("reset_state", 64'(snap()), 64'(0));
    #10 rstb = 1'b0;
    tick(); tick();
    tbl.push_back(mk( 0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk( 2, 0, 1, 0, 0, 1,  0, 1, 0, 0));
    tbl.push_back(mk( 3, 1, 1, 1, 0, 1,  0, 1, 0, 0));
    tbl.push_back(mk( 4, 0, 1, 2, 1, 1, 10, 1, 0, 0));
    tbl.push_back(mk( 5, 0, 1, 3, 1, 1, 11, 1, 0, 0));
    tbl.push_back(mk( 6, 0, 0, 4, 1, 1, 12, 1, 0, 0));
    tbl.push_back(mk( 7, 0, 0, 4, 1, 1, 13, 1, 0, 0));
    tbl.push_back(mk( 8, 0, 1, 4, 0, 1,  0, 1, 0, 0));
    tbl.push_back(mk( 9, 0, 1, 5, 0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(10, 0, 1, 6, 1, 1, 14, 1, 0, 0));
    tbl.push_back(mk(13, 0, 0, 8, 1, 1, 17, 1, 0, 0));
    tbl.push_back(mk(14, 0, 1, 8, 0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(16, 0, 1,10, 1, 1, 18, 1, 0, 0));
    tbl.push_back(mk(18, 0, 0, 0, 1, 1, 20, 1, 0, 0));
    tbl.push_back(mk(19, 0, 0, 0, 1, 1, 21, 1, 0, 0));
    tbl.push_back(mk(20, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(25, 1, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(37, 1, 0, 0, 0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(38, 0, 0, 0, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(40, 0, 0, 0, 0, 0,  0, 0, 0, 1));
    do_start();
    cyc = 0;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) begin
        tick();
        start = 1'b0;
        cyc++;
      end
      chk($sformatf("frame1_c%0d", tbl[i].cyc), 64'(snap()),
          64'({tbl[i].en, 8'(tbl[i].addr), tbl[i].hav, tbl[i].vav, 8'(tbl[i].dat),
               tbl[i].bsy, tbl[i].dn, 8'(tbl[i].fc)}));
      start = tbl[i].st;
    end
    tick();
    start = 1'b0;
    do_start();
    for (int c = 0; c < 9; c++) tick();
    chk("mid_line2", 64'({bus.rd_en, bus.rd_addr, bus.o_vav, busy}), 64'({1'b1, 18'd5, 1'b1, 1'b1}));
    #2 rstb = 1'b1;
    #1 chk("async_reset", 64'(snap()), 64'(0));
    #3 rstb = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("no_resume", 64'({busy, bus.rd_en, bus.rd_addr, bus.o_vav, frame_cnt}), 64'(0));
    cont = 1'b1;
    do_start();
    for (int c = 0; c <= 80; c++) begin
      if (c == 4) chk("cont_latency", 64'({bus.o_hav, bus.data_out}), 64'({1'b1, 8'd10}));
      if (c == 19) chk("cont_vav_last_line", 64'(bus.o_vav), 64'(1));
      if (c >= 20 && c <= 39)
        chk($sformatf("vblk_c%0d", c), 64'({bus.rd_en, bus.o_hav, bus.o_vav, bus.data_out}), 64'(0));
      if (c == 37) chk("cont_done1", 64'({done, busy, frame_cnt}), 64'({1'b1, 1'b1, 8'd0}));
      if (c == 38) chk("cont_fc1", 64'({done, busy, frame_cnt}), 64'({1'b0, 1'b1, 8'd1}));
      if (c == 40) chk("cont_restart", 64'({bus.rd_en, bus.rd_addr, bus.o_vav}), 64'({1'b1, 18'd0, 1'b1}));
      if (c == 42) chk("cont_first_pix", 64'({bus.o_hav, bus.data_out}), 64'({1'b1, 8'd10}));
      if (c == 50) cont = 1'b0;
      if (c == 75) chk("cont_done2", 64'({done, busy, frame_cnt}), 64'({1'b1, 1'b1, 8'd1}));
      if (c == 76) chk("cont_fc2", 64'({done, busy, frame_cnt}), 64'({1'b0, 1'b0, 8'd2}));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
